// File: rtl/gps_wb_regs_pkg.sv
// Shared constants for the GPS channel Wishbone register bank: register offsets inside the
// 256-byte channel window, STATUS bit positions and the snapshot count.
package gps_wb_regs_pkg;

   // Channel window width: offsets live in wb_adr_i[WIN_W-1:0]
   localparam int unsigned WIN_W = 8;

   // Number of early/prompt/late I/Q accumulators captured per dump
   localparam int unsigned NUM_ACC = 6;

   // Control (RW) registers
   localparam logic [WIN_W-1:0] OFS_CODE_FREQ  = 8'h00;
   localparam logic [WIN_W-1:0] OFS_CARR_FREQ  = 8'h04;
   localparam logic [WIN_W-1:0] OFS_CODE_OFF   = 8'h08;
   localparam logic [WIN_W-1:0] OFS_CARR_OFF   = 8'h0C;
   localparam logic [WIN_W-1:0] OFS_ACQ_THRESH = 8'h10;
   localparam logic [WIN_W-1:0] OFS_CFG        = 8'h14;

   // Snapshot (RO) registers, in snapshot index order 0..5
   localparam logic [WIN_W-1:0] OFS_IP = 8'h18;
   localparam logic [WIN_W-1:0] OFS_QP = 8'h1C;
   localparam logic [WIN_W-1:0] OFS_IL = 8'h20;
   localparam logic [WIN_W-1:0] OFS_QL = 8'h24;
   localparam logic [WIN_W-1:0] OFS_IE = 8'h28;
   localparam logic [WIN_W-1:0] OFS_QE = 8'h2C;

   localparam logic [WIN_W-1:0] OFS_STATUS = 8'h30;

   // STATUS bit positions
   localparam int unsigned ST_READY = 0;
   localparam int unsigned ST_OVR   = 1;
   localparam int unsigned ST_LOCK  = 2;

endpackage

// File: rtl/gps_acc_snapshot.sv
// Accumulator snapshot bank: captures all six accumulators on a dump strobe while no
// unread dump is pending, and tracks the dump_ready / sticky overrun flags.
module gps_acc_snapshot
   import gps_wb_regs_pkg::*;
#(
   parameter int unsigned DW = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         dump_i,
   input  logic                         clr_ready_i,
   input  logic                         clr_ovr_i,
   input  logic [NUM_ACC-1:0][DW-1:0]   acc_i,
   output logic [NUM_ACC-1:0][DW-1:0]   snap_o,
   output logic                         ready_o,
   output logic                         ovr_o
);

   logic [NUM_ACC-1:0][DW-1:0] snap_d, snap_q;
   logic                       ready_d, ready_q;
   logic                       ovr_d, ovr_q;
   logic                       ready_eff;
   logic                       capture;

   // Next state: a clear on the same edge as a dump frees the bank, so the dump captures
   // and ready stays set without flagging an overrun.
   always_comb begin
      ready_eff = ready_q & ~clr_ready_i;
      capture   = dump_i & ~ready_eff;
      snap_d    = capture ? acc_i : snap_q;
      ready_d   = capture | ready_eff;
      ovr_d     = (ovr_q & ~clr_ovr_i) | (dump_i & ready_eff);
   end

   // State registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         snap_q  <= '0;
         ready_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         snap_q  <= snap_d;
         ready_q <= ready_d;
         ovr_q   <= ovr_d;
      end
   end

   assign snap_o  = snap_q;
   assign ready_o = ready_q;
   assign ovr_o   = ovr_q;

endmodule

// File: rtl/gps_channel_wb_regs.sv
// Wishbone classic slave register bank for one GPS tracking channel: control words for the
// channel datapath, accumulator snapshots and a dump-ready status handshake.
module gps_channel_wb_regs
   import gps_wb_regs_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h00000A00,
   parameter int unsigned DW        = 32
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic [31:0]     wb_adr_i,
   input  logic [DW-1:0]   wb_dat_i,
   input  logic [DW/8-1:0] wb_sel_i,
   input  logic            wb_we_i,
   input  logic            wb_stb_i,
   input  logic            wb_cyc_i,
   output logic [DW-1:0]   wb_dat_o,
   output logic            wb_ack_o,
   input  logic            dump_i,
   input  logic [DW-1:0]   acc_ip_i,
   input  logic [DW-1:0]   acc_qp_i,
   input  logic [DW-1:0]   acc_il_i,
   input  logic [DW-1:0]   acc_ql_i,
   input  logic [DW-1:0]   acc_ie_i,
   input  logic [DW-1:0]   acc_qe_i,
   input  logic            acq_lock_i,
   output logic [DW-1:0]   code_freq_o,
   output logic [DW-1:0]   carr_freq_o,
   output logic [DW-1:0]   code_off_o,
   output logic [DW-1:0]   carr_off_o,
   output logic [DW-1:0]   acq_thresh_o,
   output logic [DW-1:0]   cfg_o,
   output logic [7:0]      sat_id_o,
   output logic            ctrl_wr_o
);

   localparam int unsigned NUM_CTRL = 6;

   logic [NUM_CTRL-1:0][DW-1:0] ctrl_d, ctrl_q;
   logic [DW-1:0]               dat_d, dat_q;
   logic                        ack_d, ack_q;
   logic                        ctrl_wr_d, ctrl_wr_q;

   logic                        hit;
   logic                        acc_en;
   logic                        wr_en;
   logic                        rd_en;
   logic [WIN_W-1:0]            ofs;
   logic                        st_wr;
   logic                        clr_ready;
   logic                        clr_ovr;
   logic [DW-1:0]               rdata;

   logic [NUM_ACC-1:0][DW-1:0]  acc_vec;
   logic [NUM_ACC-1:0][DW-1:0]  snap;
   logic                        dump_ready;
   logic                        overrun;

   // Byte lanes [1:0] carry no register selection
   logic unused_adr;
   assign unused_adr = ^wb_adr_i[1:0];

   // Bus decode: an access takes effect on the edge that raises ack
   always_comb begin
      hit    = wb_cyc_i & wb_stb_i & (wb_adr_i[31:WIN_W] == BASE_ADDR[31:WIN_W]);
      acc_en = hit & ~ack_q;
      wr_en  = acc_en & wb_we_i;
      rd_en  = acc_en & ~wb_we_i;
      ofs    = {wb_adr_i[WIN_W-1:2], 2'b00};
      // Writing 0 to a STATUS flag clears it; writing 1 leaves it alone
      st_wr     = wr_en & (ofs == OFS_STATUS) & wb_sel_i[0];
      clr_ready = st_wr & ~wb_dat_i[ST_READY];
      clr_ovr   = st_wr & ~wb_dat_i[ST_OVR];
   end

   // Control register writes, byte-gated by wb_sel_i
   always_comb begin
      ctrl_d    = ctrl_q;
      ctrl_wr_d = 1'b0;
      if (wr_en && (ofs <= OFS_CFG)) begin
         ctrl_wr_d = 1'b1;
         for (int b = 0; b < DW / 8; b++) begin
            if (wb_sel_i[b]) begin
               ctrl_d[ofs[4:2]][8*b +: 8] = wb_dat_i[8*b +: 8];
            end
         end
      end
   end

   // Read mux; snapshot reads see the pre-dump contents on a coincident dump edge
   always_comb begin
      rdata = '0;
      case (ofs)
         OFS_CODE_FREQ:  rdata = ctrl_q[0];
         OFS_CARR_FREQ:  rdata = ctrl_q[1];
         OFS_CODE_OFF:   rdata = ctrl_q[2];
         OFS_CARR_OFF:   rdata = ctrl_q[3];
         OFS_ACQ_THRESH: rdata = ctrl_q[4];
         OFS_CFG:        rdata = ctrl_q[5];
         OFS_IP:         rdata = snap[0];
         OFS_QP:         rdata = snap[1];
         OFS_IL:         rdata = snap[2];
         OFS_QL:         rdata = snap[3];
         OFS_IE:         rdata = snap[4];
         OFS_QE:         rdata = snap[5];
         OFS_STATUS: begin
            rdata[ST_READY] = dump_ready;
            rdata[ST_OVR]   = overrun;
            rdata[ST_LOCK]  = acq_lock_i;
         end
         default:        rdata = '0;
      endcase
   end

   // Ack and read-data next state; read data holds between transfers
   always_comb begin
      ack_d = acc_en;
      dat_d = rd_en ? rdata : dat_q;
   end

   // Bus-side state registers
   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         ctrl_q    <= '0;
         dat_q     <= '0;
         ack_q     <= 1'b0;
         ctrl_wr_q <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         dat_q     <= dat_d;
         ack_q     <= ack_d;
         ctrl_wr_q <= ctrl_wr_d;
      end
   end

   assign acc_vec = {acc_qe_i, acc_ie_i, acc_ql_i, acc_il_i, acc_qp_i, acc_ip_i};

   gps_acc_snapshot #(
      .DW (DW)
   ) u_snapshot (
      .clk_i       (wb_clk_i),
      .rst_ni      (wb_rst_i),
      .dump_i      (dump_i),
      .clr_ready_i (clr_ready),
      .clr_ovr_i   (clr_ovr),
      .acc_i       (acc_vec),
      .snap_o      (snap),
      .ready_o     (dump_ready),
      .ovr_o       (overrun)
   );

   assign wb_dat_o     = dat_q;
   assign wb_ack_o     = ack_q;
   assign ctrl_wr_o    = ctrl_wr_q;
   assign code_freq_o  = ctrl_q[0];
   assign carr_freq_o  = ctrl_q[1];
   assign code_off_o   = ctrl_q[2];
   assign carr_off_o   = ctrl_q[3];
   assign acq_thresh_o = ctrl_q[4];
   assign cfg_o        = ctrl_q[5];
   assign sat_id_o     = ctrl_q[5][31:24];

endmodule

// File: tb/tb_gps_channel_wb_regs.sv
// Bench for gps_channel_wb_regs: directed scenarios plus a randomized phase, all checked
// against a register-level model of the channel window.
module tb_gps_channel_wb_regs;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i, wb_stb_i, wb_cyc_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        dump_i;
   logic [31:0] tb_acc [6];
   logic        acq_lock_i;
   logic [31:0] code_freq_o, carr_freq_o, code_off_o, carr_off_o, acq_thresh_o, cfg_o;
   logic [7:0]  sat_id_o;
   logic        ctrl_wr_o;

   int checks   = 0;
   int failures = 0;
   int ctrl_cnt = 0;

   // Reference model: register contents by word, snapshot bank and flags
   logic [31:0] m_ctrl [6];
   logic [31:0] m_snap [6];
   bit          m_ready, m_ovr;
   int          m_ctrl_wr;

   always #5 clk = ~clk;

   gps_channel_wb_regs #(
      .BASE_ADDR (32'h00000A00),
      .DW        (32)
   ) dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst_n),
      .wb_adr_i     (wb_adr_i),
      .wb_dat_i     (wb_dat_i),
      .wb_sel_i     (wb_sel_i),
      .wb_we_i      (wb_we_i),
      .wb_stb_i     (wb_stb_i),
      .wb_cyc_i     (wb_cyc_i),
      .wb_dat_o     (wb_dat_o),
      .wb_ack_o     (wb_ack_o),
      .dump_i       (dump_i),
      .acc_ip_i     (tb_acc[0]),
      .acc_qp_i     (tb_acc[1]),
      .acc_il_i     (tb_acc[2]),
      .acc_ql_i     (tb_acc[3]),
      .acc_ie_i     (tb_acc[4]),
      .acc_qe_i     (tb_acc[5]),
      .acq_lock_i   (acq_lock_i),
      .code_freq_o  (code_freq_o),
      .carr_freq_o  (carr_freq_o),
      .code_off_o   (code_off_o),
      .carr_off_o   (carr_off_o),
      .acq_thresh_o (acq_thresh_o),
      .cfg_o        (cfg_o),
      .sat_id_o     (sat_id_o),
      .ctrl_wr_o    (ctrl_wr_o)
   );

   // Count control-write pulses mid-cycle
   always @(negedge clk) if (ctrl_wr_o === 1'b1) ctrl_cnt++;

   initial begin
      #1ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [7:0] o);
      if (o < 8'h18) return m_ctrl[o >> 2];
      if (o < 8'h30) return m_snap[(o - 8'h18) >> 2];
      if (o == 8'h30) return {29'd0, acq_lock_i, m_ovr, m_ready};
      return 32'd0;
   endfunction

   // Apply one acked access to the model: clears take effect first, then any dump
   task automatic model_apply(input bit we, input logic [7:0] o, input logic [31:0] d,
                              input logic [3:0] sel, input bit dmp);
      bit clr_r = 0;
      bit clr_o = 0;
      if (we) begin
         if (o <= 8'h14) begin
            for (int b = 0; b < 4; b++)
               if (sel[b]) m_ctrl[o >> 2][8*b +: 8] = d[8*b +: 8];
            m_ctrl_wr++;
         end else if (o == 8'h30 && sel[0]) begin
            clr_r = !d[0];
            clr_o = !d[1];
         end
      end
      if (clr_r) m_ready = 0;
      if (clr_o) m_ovr = 0;
      if (dmp) begin
         if (!m_ready) begin
            m_snap  = tb_acc;
            m_ready = 1;
         end else begin
            m_ovr = 1;
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 6; i++) begin
         m_ctrl[i] = '0;
         m_snap[i] = '0;
      end
      m_ready = 0;
      m_ovr   = 0;
   endtask

   // One Wishbone transfer, ack bounded to 16 cycles; ack must last exactly one cycle
   task automatic bus_xfer(input bit we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, input bit with_dump, input bit exp_ack,
                           output logic [31:0] rdat);
      bit acked = 0;
      rdat = '0;
      @(negedge clk);
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we;
      wb_adr_i = adr; wb_dat_i = wdat; wb_sel_i = sel; dump_i = with_dump;
      for (int i = 0; i < 16 && !acked; i++) begin
         @(posedge clk); #1;
         dump_i = 0;
         if (wb_ack_o === 1'b1) begin
            acked = 1;
            rdat  = wb_dat_o;
         end
      end
      @(negedge clk);
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
      check($sformatf("ack_seen@%h", adr), {31'd0, acked}, {31'd0, exp_ack});
      if (acked) begin
         @(posedge clk); #1;
         check($sformatf("ack_width@%h", adr), {31'd0, wb_ack_o}, 32'd0);
      end
   endtask

   task automatic do_write(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel,
                           input bit with_dump);
      logic [31:0] rd;
      bus_xfer(1, adr, d, sel, with_dump, 1, rd);
      model_apply(1, adr[7:0] & 8'hFC, d, sel, with_dump);
   endtask

   task automatic do_read(input logic [31:0] adr, input bit with_dump, input string tag);
      logic [31:0] rd, exp;
      exp = model_read(adr[7:0] & 8'hFC);
      bus_xfer(0, adr, 32'h0, 4'h0, with_dump, 1, rd);
      model_apply(0, adr[7:0] & 8'hFC, 32'h0, 4'h0, with_dump);
      check(tag, rd, exp);
   endtask

   task automatic pulse_dump();
      @(negedge clk);
      dump_i = 1;
      @(negedge clk);
      dump_i = 0;
      model_apply(0, 8'hFC, 32'h0, 4'h0, 1);
   endtask

   task automatic check_outputs(input string tag);
      @(negedge clk);
      check({tag, ".code_freq"}, code_freq_o, m_ctrl[0]);
      check({tag, ".carr_freq"}, carr_freq_o, m_ctrl[1]);
      check({tag, ".code_off"}, code_off_o, m_ctrl[2]);
      check({tag, ".carr_off"}, carr_off_o, m_ctrl[3]);
      check({tag, ".acq_thresh"}, acq_thresh_o, m_ctrl[4]);
      check({tag, ".cfg"}, cfg_o, m_ctrl[5]);
      check({tag, ".sat_id"}, {24'd0, sat_id_o}, {24'd0, m_ctrl[5][31:24]});
   endtask

   initial begin
      logic [31:0] rd;
      int          ack_hist;

      rst_n = 1; wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0;
      wb_we_i = 0; wb_stb_i = 0; wb_cyc_i = 0; dump_i = 0; acq_lock_i = 0;
      for (int i = 0; i < 6; i++) tb_acc[i] = '0;
      model_reset();
      m_ctrl_wr = 0;
      #2 rst_n = 0;
      #20;
      check("rst.ack", {31'd0, wb_ack_o}, 32'd0);
      check("rst.dat", wb_dat_o, 32'd0);
      check("rst.ctrl_wr", {31'd0, ctrl_wr_o}, 32'd0);
      check_outputs("rst");
      @(negedge clk) rst_n = 1;

      // Control writes and readback
      do_write(32'hA04, 32'h0FB82165, 4'hF, 0);
      do_write(32'hA00, 32'h16EA4A8C, 4'hF, 0);
      do_write(32'hA14, 32'h1409A1BE, 4'hF, 0);
      check("ctrl_wr.count3", ctrl_cnt, 32'd3);
      do_read(32'hA04, 0, "rd.carr_freq");
      do_read(32'hA00, 0, "rd.code_freq");
      do_read(32'hA14, 0, "rd.cfg");
      check("sat_id", {24'd0, sat_id_o}, 32'h14);

      // Byte-lane gating
      do_write(32'hA10, 32'hFFFFFFFF, 4'b0010, 0);
      check("thresh.sel", acq_thresh_o, 32'h0000FF00);
      check_outputs("ctrl");

      // Single dump, readback and clear
      tb_acc[0] = 32'h12345678; tb_acc[1] = 32'h11111111; tb_acc[2] = 32'h22222222;
      tb_acc[3] = 32'h33333333; tb_acc[4] = 32'h44444444; tb_acc[5] = 32'h55555555;
      pulse_dump();
      do_read(32'hA30, 0, "status.ready");
      check("status.ready.const", model_read(8'h30), 32'h1);
      do_read(32'hA18, 0, "snap.ip");
      do_read(32'hA2C, 0, "snap.qe");
      do_write(32'hA30, 32'h0, 4'h1, 0);
      do_read(32'hA30, 0, "status.cleared");

      // Overrun: second dump does not overwrite
      pulse_dump();
      tb_acc[0] = 32'hDEADBEEF;
      pulse_dump();
      do_read(32'hA18, 0, "ovr.ip_held");
      check("ovr.ip_held.const", model_read(8'h18), 32'h12345678);
      do_read(32'hA30, 0, "ovr.status");
      check("ovr.status.const", model_read(8'h30), 32'h3);
      do_write(32'hA30, 32'h0, 4'h1, 0);
      do_read(32'hA30, 0, "ovr.cleared");

      // Writing ones to STATUS changes nothing; sel without byte0 does not clear
      pulse_dump();
      do_write(32'hA30, 32'h3, 4'h1, 0);
      do_write(32'hA30, 32'h0, 4'hE, 0);
      do_read(32'hA30, 0, "status.no_clear");

      // Dump coincident with a clearing write: capture wins, no overrun
      tb_acc[0] = 32'hCAFEF00D;
      do_write(32'hA30, 32'h0, 4'h1, 1);
      do_read(32'hA30, 0, "simul.status");
      do_read(32'hA18, 0, "simul.ip");

      // Snapshot read coincident with a dump returns the old value
      do_write(32'hA30, 32'h0, 4'h1, 0);
      tb_acc[0] = 32'hA5A55A5A;
      do_read(32'hA18, 1, "rd_dump.old");
      do_read(32'hA18, 0, "rd_dump.new");

      // Misses never ack; unmapped in-window offsets ack and read 0
      bus_xfer(0, 32'hB00, 32'h0, 4'h0, 0, 0, rd);
      bus_xfer(1, 32'hB00, 32'hFFFFFFFF, 4'hF, 0, 0, rd);
      do_write(32'hA40, 32'hFFFFFFFF, 4'hF, 0);
      do_read(32'hA40, 0, "unmapped.rd");
      do_write(32'hA18, 32'hFFFFFFFF, 4'hF, 0);
      do_read(32'hA18, 0, "ro.ignored");
      check_outputs("miss");

      // Held strobe acks every second cycle
      @(negedge clk);
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'hA00;
      ack_hist = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         ack_hist = (ack_hist << 1) | int'(wb_ack_o === 1'b1);
      end
      check("held.ack_pattern", ack_hist, 32'b1010);
      @(negedge clk);
      wb_cyc_i = 0; wb_stb_i = 0;
      @(negedge clk);

      // Randomized accesses against the model
      for (int n = 0; n < 60; n++) begin
         int          op;
         logic [7:0]  o;
         logic [31:0] adr;
         op = $urandom_range(0, 4);
         o  = 8'($urandom_range(0, 15) * 4);
         adr = {24'h00000A, o[7:2], 2'($urandom_range(0, 3))};
         acq_lock_i = 1'($urandom_range(0, 1));
         if (op == 2 || op == 4)
            for (int i = 0; i < 6; i++) tb_acc[i] = $urandom;
         case (op)
            0: do_write({24'h00000A, 8'($urandom_range(0, 5) * 4)}, $urandom,
                        4'($urandom_range(0, 15)), 0);
            1: do_read(adr, 0, $sformatf("rand.rd@%h", adr));
            2: pulse_dump();
            3: do_write(32'hA30, 32'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 0);
            default: do_write(32'hA30, 32'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1);
         endcase
      end
      for (int i = 0; i < 13; i++) do_read(32'hA00 + 32'(i * 4), 0, $sformatf("sweep@%0h", i * 4));
      check_outputs("rand");
      check("ctrl_wr.count", ctrl_cnt, m_ctrl_wr);

      // Reset while ack is high drops it immediately
      @(negedge clk);
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'hA00;
      @(posedge clk); #1;
      rst_n = 0;
      #1;
      check("rst_mid.ack_drop", {31'd0, wb_ack_o}, 32'd0);
      check("rst_mid.dat", wb_dat_o, 32'd0);
      wb_cyc_i = 0; wb_stb_i = 0;
      model_reset();
      @(negedge clk) rst_n = 1;

      // Reset before the committing edge of a held write: register is not written
      do_write(32'hA14, 32'hAABBCCDD, 4'hF, 0);
      @(negedge clk);
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 32'hA08;
      wb_dat_i = 32'h55AA55AA; wb_sel_i = 4'hF;
      #2 rst_n = 0;
      #1;
      model_reset();
      check("rst_wr.ack", {31'd0, wb_ack_o}, 32'd0);
      check("rst_wr.ctrl_wr", {31'd0, ctrl_wr_o}, 32'd0);
      check("rst_wr.cfg", cfg_o, 32'd0);
      @(posedge clk); #1;
      check("rst_wr.ack_held", {31'd0, wb_ack_o}, 32'd0);
      @(negedge clk);
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
      rst_n = 1;
      check_outputs("rst_wr");
      do_read(32'hA08, 0, "rst_wr.code_off");
      do_read(32'hA30, 0, "rst_wr.status");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gps_channel_wb_regs.md
Name: gps_channel_wb_regs

Overview:
Wishbone classic slave register bank for one GPS tracking channel. It is the responder side of the bus the firmware/BFM master drives.
- Holds the NCO frequency, offset, threshold and config control words and presents them to the channel datapath.
- On each channel dump strobe, snapshots the six early/prompt/late I/Q accumulators.
- Exposes a status register with a dump-ready handshake, cleared by software.
- Instantiated once per channel inside gps_multichannel, one window per channel.

Parameters:
BASE_ADDR, 32'h00000A00, channel window base; decoded on wb_adr_i[31:8].
DW, 32, Wishbone data width and width of every register.

Ports:
wb_clk_i  in  1  bus/system clock
wb_rst_i  in  1  asynchronous, active-low reset
wb_adr_i  in  32  byte address
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte enables
wb_we_i  in  1  write enable
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle
wb_dat_o  out  32  read data
wb_ack_o  out  1  acknowledge
dump_i  in  1  one-cycle pulse: accumulators valid, wb_clk_i domain
acc_ip_i, acc_qp_i, acc_il_i, acc_ql_i, acc_ie_i, acc_qe_i  in  32 each  accumulator values
acq_lock_i  in  1  live acquisition-lock flag
code_freq_o, carr_freq_o, code_off_o, carr_off_o, acq_thresh_o, cfg_o  out  32 each  control words
sat_id_o  out  8  cfg_o[31:24]
ctrl_wr_o  out  1  one-cycle pulse on any control-register write

Behaviour:
- Reset (wb_rst_i=0, asynchronous): all registers, wb_dat_o, wb_ack_o and ctrl_wr_o go to 0.
- Hit condition: wb_cyc_i & wb_stb_i & (wb_adr_i[31:8]==BASE_ADDR[31:8]). Offset is wb_adr_i[7:0] with bits[1:0] ignored.
- Ack timing: wb_ack_o <= hit & ~wb_ack_o. Ack is a single-cycle registered pulse, one cycle after the strobe rises. For a held strobe it pulses every second cycle.
- Misses never ack.
- Writes are committed on the same edge that raises ack. wb_sel_i gates each byte of RW registers.
- Read data is registered on the same edge and valid while ack=1. wb_dat_o is held otherwise.
- Register map (RW: 0x00 code_freq, 0x04 carr_freq, 0x08 code_off, 0x0C carr_off, 0x10 acq_thresh, 0x14 cfg):
  - 0x18 IP, 0x1C QP, 0x20 IL, 0x24 QL, 0x28 IE, 0x2C QE: RO snapshots.
  - 0x30 STATUS: bit0 dump_ready, bit1 overrun, bit2 acq_lock_i (live), bits[31:3] read 0.
- Unmapped in-window offsets (0x34–0xFC): acked, read 0, writes ignored. RO registers ignore writes but are acked.
- ctrl_wr_o pulses on the ack edge of a write to 0x00–0x14, regardless of wb_sel_i.
- Snapshot/status behaviour:
  - dump_i with dump_ready=0: copy all six accumulators, set dump_ready.
  - dump_i with dump_ready=1: snapshots held (not overwritten), overrun set sticky.
  - STATUS write with byte0 selected: bit0=0 clears dump_ready, bit1=0 clears overrun; writing 1 has no effect.
- Simultaneous dump_i and a clearing STATUS write on the same edge:
  - The set wins; snapshots update, dump_ready stays 1.
  - overrun is not set, because ready was being cleared.
- A read of a snapshot register coincident with dump_i returns the pre-dump value.
- Reset mid-transfer: ack is dropped immediately and the transfer is lost; the master must reissue it.

Decomposition:
- Package gps_wb_regs_pkg holds the offset constants (OFS_CODE_FREQ … OFS_STATUS), the status bit indices (ST_READY=0, ST_OVR=1, ST_LOCK=2) and the window width (8 bits).
- One natural sub-module, gps_acc_snapshot: six capture registers plus the ready/overrun logic, driven by dump_i and the clear strobe.
- Bus decode and the control registers stay at top level.

Test Plan:
- Write 0x0FB82165 to 0xA04, 0x16EA4A8C to 0xA00, 0x1409A1BE to 0xA14, then read back -> identical values, sat_id_o=0x14, ctrl_wr_o pulsed 3 times, each ack exactly 1 cycle.
- Write 0xFFFFFFFF to 0xA10 with wb_sel_i=4'b0010, starting from 0 -> acq_thresh_o=0x0000FF00.
- Set acc_ip_i=0x12345678 and the others to distinct values, pulse dump_i -> STATUS reads 0x1 (lock=0); 0xA18 reads 0x12345678; write STATUS 0x0 -> reads 0x0.
- Two dump_i pulses without a clear, with the second carrying acc_ip_i=0xDEADBEEF -> 0xA18 still reads the first value, STATUS=0x3; write 0x0 -> STATUS=0x0.
- Access 0xB00 with BASE=0xA00 -> no ack for 16 cycles. Access 0xA40 -> ack, read 0.
- Assert reset mid-write while stb is held -> ack=0 and all outputs 0 in the same cycle; the register is not written.
